// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_pkg
// Brief    : Shared types and constants for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IF_BOOT  = 2'd0,
        IF_RUN   = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_if
// Brief    : Instruction memory req/gnt/rvalid bus between fetch and memory.
// Revision : 1.0
// ============================================================================
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface
`default_nettype wire

// File: rtl/if_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Circular-buffer FIFO with flush; holds fetched words or PC tags.
// Revision : 1.0
// ============================================================================
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         push_i,
    input  wire T                             data_i,
    input  wire logic                         pop_i,
    input  wire logic                         flush_i,
    output T                                  data_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic [$clog2(DEPTH+1)-1:0]        count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T                mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch: PC, credit-limited memory requests, fetch
//            buffer, decode handshake and redirect flush of wrong-path words.
// Revision : 1.0
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IF_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    if_stage_if.master       imem,
    input  wire logic        redirect_i,
    input  wire logic [31:0] redirect_pc_i,
    input  wire logic        id_ready_i,
    output logic             if_valid_o,
    output logic [31:0]      instruction_o,
    output logic [31:0]      pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_BOOT  = IF_BOOT;
    localparam logic [1:0] S_RUN   = IF_RUN;
    localparam logic [1:0] S_DRAIN = IF_DRAIN;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] stale_q, stale_d;
    logic [CW-1:0] outst_rsp;
    logic [CW:0]   credit_used;

    logic          fire, fifo_push, fifo_pop;
    logic          fifo_empty, fifo_full, tag_empty, tag_full;
    logic [CW-1:0] fifo_count, tag_count;
    fetch_entry_t  fifo_wdata, fifo_head;
    logic [31:0]   tag_head;
    logic          unused_flags;

    assign fifo_pop = if_valid_o && id_ready_i;

    // A slot freed by this cycle's pop is counted as free so that a depth-2
    // buffer with 1-cycle memory sustains one word per cycle.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outst_q} - (CW+1)'(fifo_pop);

    assign imem.req  = (state_q == S_RUN) && (credit_used < (CW+1)'(FIFO_DEPTH)) && !redirect_i;
    assign imem.addr = pc_q;
    assign fire      = imem.req && imem.gnt;

    assign fifo_push  = imem.rvalid && (stale_q == '0) && !redirect_i;
    assign fifo_wdata = '{pc: tag_head, instr: imem.rdata};
    assign outst_rsp  = outst_q - CW'(imem.rvalid);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        outst_d = outst_q;
        stale_d = stale_q;
        if (redirect_i) begin
            pc_d    = word_align(redirect_pc_i);
            outst_d = outst_rsp;
            stale_d = outst_rsp;
            state_d = (outst_rsp != '0) ? S_DRAIN : S_RUN;
        end else begin
            if (fire) pc_d = pc_q + 32'd4;
            outst_d = outst_rsp + CW'(fire);
            if (imem.rvalid && (stale_q != '0)) stale_d = stale_q - 1'b1;
            case (state_q)
                S_BOOT:  state_d = S_RUN;
                S_DRAIN: if (stale_d == '0) state_d = S_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            stale_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            stale_q <= stale_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_data_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .flush_i (redirect_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // PC of every live (non-stale) outstanding request, in issue order.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (logic [31:0])
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fire),
        .data_i  (pc_q),
        .pop_i   (fifo_push),
        .flush_i (redirect_i),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count)
    );

    assign unused_flags = ^{fifo_full, tag_full, tag_empty, tag_count};

    assign if_valid_o    = !fifo_empty;
    assign instruction_o = if_valid_o ? fifo_head.instr : NOP_INSTR;
    assign pc_o          = if_valid_o ? fifo_head.pc    : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Directed self-checking bench for if_stage with a queued memory model.
// Revision : 1.0
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b1;
    logic        if_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        resp_en = 1'b1;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] pend [$];

    if_stage_if bus ();

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (bus),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .id_ready_i    (id_ready),
        .if_valid_o    (if_valid),
        .instruction_o (instr),
        .pc_o          (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'hFF10_4013 : {8'hC3, a[23:0]};
    endfunction

    // Memory: grants every request, answers one cycle later in order unless held.
    assign bus.gnt = bus.req;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            bus.rvalid <= 1'b0;
            bus.rdata  <= 32'h0;
        end else begin
            if (bus.req && bus.gnt) pend.push_back(bus.addr);
            if (resp_en && pend.size() > 0) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= mem_word(pend.pop_front());
            end else begin
                bus.rvalid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            if (i > 0) step();
            #1;
            ok = bus.req;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            if (i > 0) step();
            #1;
            ok = if_valid;
        end
    endtask

    initial begin
        bit          ok;
        int          got;
        int          rv_cnt;
        bit          early_valid;
        logic [31:0] exp_pc;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst_req",   bus.req,  1'b0);
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_instr", instr,    32'h0000_0013);
        chk("rst_pc",    pc,       32'h0);

        // 1: boot cycle, first request, latency
        rst = 1'b0;
        #1;
        chk("boot_req", bus.req, 1'b0);
        step(); #1;
        chk("first_req",  bus.req,  1'b1);
        chk("first_addr", bus.addr, 32'h0);
        step(); step();

        // 2: streaming 0x0..0xC
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stream_valid", if_valid, 1'b1);
            chk("stream_pc",    pc,       32'(k * 4));
            chk("stream_instr", instr,    (k == 0) ? 32'hFF10_4013 : mem_word(32'(k * 4)));
            step();
        end

        // 3: decode stall for 5 cycles
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_req",   bus.req,  1'b0);
            chk("stall_valid", if_valid, 1'b1);
            chk("stall_pc",    pc,       32'h10);
            chk("stall_instr", instr,    32'hC300_0010);
            step();
        end
        id_ready = 1'b1;
        exp_pc = 32'h10;
        got = 0;
        for (int i = 0; i < 12 && got < 4; i++) begin
            if (i > 0) step();
            #1;
            if (if_valid) begin
                chk("resume_pc", pc, exp_pc);
                exp_pc += 32'd4;
                got++;
            end
        end
        chk("resume_count", 32'(got), 32'd4);

        // 4: redirect to 0x100 with 2 requests outstanding
        step();
        resp_en = 1'b0;
        repeat (5) step();
        #1;
        chk("credit_full_req", bus.req,  1'b0);
        chk("drained_valid",   if_valid, 1'b0);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        #1;
        chk("post_redir_valid", if_valid, 1'b0);
        chk("drain_req",        bus.req,  1'b0);
        step(); #1;
        chk("drain_hold_req", bus.req, 1'b0);
        resp_en = 1'b1;
        rv_cnt = 0;
        early_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step(); #1;
            if (bus.rvalid) rv_cnt++;
            if (if_valid) early_valid = 1'b1;
            ok = bus.req;
        end
        chk("drain_exit",      32'(ok),      32'd1);
        chk("stale_rsp_count", 32'(rv_cnt),  32'd2);
        chk("stale_dropped",   32'(early_valid), 32'd0);
        chk("redir_addr",      bus.addr,     32'h100);
        wait_valid(ok);
        chk("redir_valid", 32'(ok), 32'd1);
        chk("redir_pc",    pc,      32'h100);
        chk("redir_instr", instr,   32'hC300_0100);

        // 5: unaligned redirect target, then PC wrap
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        #1;
        chk("redir_cycle_req", bus.req, 1'b0);
        step();
        redirect = 1'b0;
        wait_req(ok);
        chk("align_req",  32'(ok), 32'd1);
        chk("align_addr", bus.addr, 32'h100);
        step();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        wait_req(ok);
        chk("top_req",  32'(ok),  32'd1);
        chk("top_addr", bus.addr, 32'hFFFF_FFFC);
        step(); #1;
        chk("wrap_req",  bus.req,  1'b1);
        chk("wrap_addr", bus.addr, 32'h0);
        wait_valid(ok);
        chk("top_valid", 32'(ok), 32'd1);
        chk("top_pc",    pc,      32'hFFFF_FFFC);
        chk("top_instr", instr,   32'hC3FF_FFFC);
        step();
        wait_valid(ok);
        chk("wrap_valid", 32'(ok), 32'd1);
        chk("wrap_pc",    pc,      32'h0);
        chk("wrap_instr", instr,   32'hFF10_4013);

        // 6: asynchronous reset mid-operation
        id_ready = 1'b0;
        repeat (4) step();
        #1;
        chk("pre_rst_valid", if_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", if_valid, 1'b0);
        chk("mid_rst_req",   bus.req,  1'b0);
        chk("mid_rst_instr", instr,    32'h0000_0013);
        chk("mid_rst_pc",    pc,       32'h0);
        step();
        rst = 1'b0;
        id_ready = 1'b1;
        #1;
        chk("reboot_req", bus.req, 1'b0);
        step(); #1;
        chk("restart_req",  bus.req,  1'b1);
        chk("restart_addr", bus.addr, 32'h0);
        step(); step(); #1;
        chk("restart_valid", if_valid, 1'b1);
        chk("restart_pc",    pc,       32'h0);
        chk("restart_instr", instr,    32'hFF10_4013);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation did not finish");
    end

endmodule
`default_nettype wire
